axi_bram_slave: RTL

AXI responder at the far end of the ETH master bus: it accepts write and read bursts, stores data in an internal dual-port word memory, and returns write responses and read data carrying the request ID.

---
 rtl/axi_pkg.sv | 13 +
 rtl/simple_dpram.sv | 31 +++
 rtl/axi_bram_slave.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared AXI encodings for the ETH master bus responders.
package axi_pkg;
  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;
endpackage

// File: rtl/simple_dpram.sv
// Word memory with one byte-masked write port and one synchronous read port.
module simple_dpram #(
  parameter int unsigned WORDS = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic [3:0]    wr_be,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data
);
  logic [31:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Read samples the pre-write contents when both ports hit the same word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/axi_bram_slave.sv
// AXI burst responder backed by a dual-port word memory; independent read and write FSMs.
module axi_bram_slave
  import axi_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic        SLAVE_CLK,
  input  logic        SLAVE_RSTN,
  input  logic [1:0]  SLAVE_WR_ADDR_ID,
  input  logic [31:0] SLAVE_WR_ADDR,
  input  logic [7:0]  SLAVE_WR_ADDR_LEN,
  input  logic [1:0]  SLAVE_WR_ADDR_BURST,
  input  logic        SLAVE_WR_ADDR_VALID,
  output logic        SLAVE_WR_ADDR_READY,
  input  logic [31:0] SLAVE_WR_DATA,
  input  logic [3:0]  SLAVE_WR_STRB,
  input  logic        SLAVE_WR_DATA_LAST,
  input  logic        SLAVE_WR_DATA_VALID,
  output logic        SLAVE_WR_DATA_READY,
  output logic [1:0]  SLAVE_WR_BACK_ID,
  output logic [1:0]  SLAVE_WR_BACK_RESP,
  output logic        SLAVE_WR_BACK_VALID,
  input  logic        SLAVE_WR_BACK_READY,
  input  logic [1:0]  SLAVE_RD_ADDR_ID,
  input  logic [31:0] SLAVE_RD_ADDR,
  input  logic [7:0]  SLAVE_RD_ADDR_LEN,
  input  logic [1:0]  SLAVE_RD_ADDR_BURST,
  input  logic        SLAVE_RD_ADDR_VALID,
  output logic        SLAVE_RD_ADDR_READY,
  output logic [1:0]  SLAVE_RD_BACK_ID,
  output logic [31:0] SLAVE_RD_DATA,
  output logic [1:0]  SLAVE_RD_DATA_RESP,
  output logic        SLAVE_RD_DATA_LAST,
  output logic        SLAVE_RD_DATA_VALID,
  input  logic        SLAVE_RD_DATA_READY
);
  localparam int unsigned AW   = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [31:0] SPAN = 32'(4 * MEM_WORDS);

  function automatic logic in_range(input logic [31:0] a);
    return ((a & 32'hFFFF_FFFC) >= BASE_ADDR) &&
           (((a & 32'hFFFF_FFFC) - BASE_ADDR) < SPAN);
  endfunction

  function automatic logic [AW-1:0] word_of(input logic [31:0] a);
    return AW'((a - BASE_ADDR) >> 2);
  endfunction

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  w_state_e      w_state;
  logic [1:0]    w_id;
  logic [AW-1:0] w_addr;
  logic [7:0]    w_len, w_cnt;
  logic          w_fixed, w_ok, w_slverr;

  r_state_e      r_state;
  logic [AW-1:0] r_addr, r_next, ram_rd_addr;
  logic [7:0]    r_len, r_cnt;
  logic          r_fixed, r_ok;
  logic          ar_hs, r_hs, ram_rd_en, ram_wr_en;
  logic [31:0]   ram_q;

  always_comb begin
    ram_wr_en   = SLAVE_WR_DATA_READY && SLAVE_WR_DATA_VALID && w_ok;
    ar_hs       = SLAVE_RD_ADDR_READY && SLAVE_RD_ADDR_VALID;
    r_hs        = SLAVE_RD_DATA_VALID && SLAVE_RD_DATA_READY;
    r_next      = r_fixed ? r_addr : r_addr + 1'b1;
    // Next beat is fetched in the handshake cycle so beats stream at one per clock.
    ram_rd_en   = ar_hs || (r_hs && !SLAVE_RD_DATA_LAST);
    ram_rd_addr = ar_hs ? word_of(SLAVE_RD_ADDR) : r_next;
    SLAVE_RD_DATA = r_ok ? ram_q : '0;
  end

  simple_dpram #(.WORDS(MEM_WORDS), .AW(AW)) u_ram (
    .clk     (SLAVE_CLK),
    .rst_n   (SLAVE_RSTN),
    .wr_en   (ram_wr_en),
    .wr_addr (w_addr),
    .wr_data (SLAVE_WR_DATA),
    .wr_be   (SLAVE_WR_STRB),
    .rd_en   (ram_rd_en),
    .rd_addr (ram_rd_addr),
    .rd_data (ram_q)
  );

  always_ff @(posedge SLAVE_CLK or negedge SLAVE_RSTN) begin
    if (!SLAVE_RSTN) begin
      w_state             <= W_IDLE;
      w_id                <= '0;
      w_addr              <= '0;
      w_len               <= '0;
      w_cnt               <= '0;
      w_fixed             <= 1'b0;
      w_ok                <= 1'b0;
      w_slverr            <= 1'b0;
      SLAVE_WR_ADDR_READY <= 1'b0;
      SLAVE_WR_DATA_READY <= 1'b0;
      SLAVE_WR_BACK_ID    <= '0;
      SLAVE_WR_BACK_RESP  <= '0;
      SLAVE_WR_BACK_VALID <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (SLAVE_WR_ADDR_READY && SLAVE_WR_ADDR_VALID) begin
            w_id                <= SLAVE_WR_ADDR_ID;
            w_addr              <= word_of(SLAVE_WR_ADDR);
            w_len               <= SLAVE_WR_ADDR_LEN;
            w_cnt               <= '0;
            w_fixed             <= (SLAVE_WR_ADDR_BURST == BURST_FIXED);
            w_ok                <= in_range(SLAVE_WR_ADDR);
            w_slverr            <= 1'b0;
            SLAVE_WR_ADDR_READY <= 1'b0;
            SLAVE_WR_DATA_READY <= 1'b1;
            w_state             <= W_DATA;
          end else begin
            SLAVE_WR_ADDR_READY <= 1'b1;
          end
        end
        W_DATA: begin
          if (SLAVE_WR_DATA_VALID) begin
            if (!w_fixed) w_addr <= w_addr + 1'b1;
            w_cnt <= w_cnt + 8'd1;
            if (w_cnt == w_len) begin
              SLAVE_WR_DATA_READY <= 1'b0;
              SLAVE_WR_BACK_VALID <= 1'b1;
              SLAVE_WR_BACK_ID    <= w_id;
              if (!w_ok)                                  SLAVE_WR_BACK_RESP <= RESP_DECERR;
              else if (w_slverr || !SLAVE_WR_DATA_LAST)   SLAVE_WR_BACK_RESP <= RESP_SLVERR;
              else                                        SLAVE_WR_BACK_RESP <= RESP_OKAY;
              w_state <= W_RESP;
            end else if (SLAVE_WR_DATA_LAST) begin
              w_slverr <= 1'b1;
            end
          end
        end
        W_RESP: begin
          if (SLAVE_WR_BACK_READY) begin
            SLAVE_WR_BACK_VALID <= 1'b0;
            SLAVE_WR_ADDR_READY <= 1'b1;
            w_state             <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge SLAVE_CLK or negedge SLAVE_RSTN) begin
    if (!SLAVE_RSTN) begin
      r_state             <= R_IDLE;
      r_addr              <= '0;
      r_len               <= '0;
      r_cnt               <= '0;
      r_fixed             <= 1'b0;
      r_ok                <= 1'b0;
      SLAVE_RD_ADDR_READY <= 1'b0;
      SLAVE_RD_BACK_ID    <= '0;
      SLAVE_RD_DATA_RESP  <= '0;
      SLAVE_RD_DATA_LAST  <= 1'b0;
      SLAVE_RD_DATA_VALID <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            r_addr              <= word_of(SLAVE_RD_ADDR);
            r_len               <= SLAVE_RD_ADDR_LEN;
            r_cnt               <= '0;
            r_fixed             <= (SLAVE_RD_ADDR_BURST == BURST_FIXED);
            r_ok                <= in_range(SLAVE_RD_ADDR);
            SLAVE_RD_BACK_ID    <= SLAVE_RD_ADDR_ID;
            SLAVE_RD_DATA_RESP  <= in_range(SLAVE_RD_ADDR) ? RESP_OKAY : RESP_DECERR;
            SLAVE_RD_DATA_LAST  <= (SLAVE_RD_ADDR_LEN == 8'd0);
            SLAVE_RD_DATA_VALID <= 1'b1;
            SLAVE_RD_ADDR_READY <= 1'b0;
            r_state             <= R_DATA;
          end else begin
            SLAVE_RD_ADDR_READY <= 1'b1;
          end
        end
        R_DATA: begin
          if (r_hs) begin
            if (SLAVE_RD_DATA_LAST) begin
              SLAVE_RD_DATA_VALID <= 1'b0;
              SLAVE_RD_DATA_LAST  <= 1'b0;
              SLAVE_RD_ADDR_READY <= 1'b1;
              r_state             <= R_IDLE;
            end else begin
              r_addr             <= r_next;
              r_cnt              <= r_cnt + 8'd1;
              SLAVE_RD_DATA_LAST <= (r_cnt + 8'd1 == r_len);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end
endmodule
